// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin arbiter sharing one UART transmitter among N_REQ
//           byte producers; holds each grant until the transmitter's tx_done.
//           Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_DONE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    w_last_grant_nxt;

  logic [N_REQ-1:0]    w_req_ready_nxt;
  logic                w_tx_start_nxt;
  logic [DATA_W-1:0]   w_tx_data_nxt;
  logic [IDX_W-1:0]    w_grant_id_nxt;
  logic                w_busy_nxt;
  logic                w_timeout_nxt;

  logic                w_any_valid;
  logic [IDX_W-1:0]    w_sel;
  logic [IDX_W-1:0]    w_scan_idx;
  logic                w_wd_expired;

  logic [DATA_W-1:0]   w_req_byte [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_byte[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the farthest offset down to the nearest, so the nearest
  // requester after last_grant is the one left in w_sel.
  always_comb begin
    w_any_valid = 1'b0;
    w_sel       = r_last_grant;
    w_scan_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_scan_idx = IDX_W'((int'(r_last_grant) + k) % N_REQ);
      if (req_valid[w_scan_idx]) begin
        w_any_valid = 1'b1;
        w_sel       = w_scan_idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_wd_limit = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wd_cnt;

  // Zero in IDLE so the count starts fresh on every entry to WAIT_DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT_DONE) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_wd_expired = (r_state == S_WAIT_DONE) && (r_wd_cnt == c_wd_limit);
`else
  assign w_wd_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_req_ready_nxt  = '0;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = tx_data;
    w_grant_id_nxt   = grant_id;
    w_busy_nxt       = busy;
    w_timeout_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_tx_data_nxt          = w_req_byte[w_sel];
          w_tx_start_nxt         = 1'b1;
          w_req_ready_nxt[w_sel] = 1'b1;
          w_grant_id_nxt         = w_sel;
          w_last_grant_nxt       = w_sel;
          w_busy_nxt             = 1'b1;
          w_state_nxt            = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A completion in the same cycle as expiry counts as a normal finish.
        if (tx_done) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_wd_expired) begin
          w_timeout_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= c_last_idx;
      req_ready    <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      req_ready    <= w_req_ready_nxt;
      tx_start     <= w_tx_start_nxt;
      tx_data      <= w_tx_data_nxt;
      grant_id     <= w_grant_id_nxt;
      busy         <= w_busy_nxt;
      timeout_err  <= w_timeout_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Self-checking bench for uart_tx_arbiter against a round-robin
//           reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GW = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO  = 16;
  localparam int GAP = 10;
`else
  localparam int TO  = 4096;
  localparam int GAP = 20;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_done;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           timeout_err;

  int tests_run = 0;
  int fails     = 0;
  int model_last;
  logic [W-1:0] model_txd;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .DATA_W         (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference: first valid index at offset 1..N after the previous grant.
  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] byte_of(logic [N*W-1:0] d, int i);
    return d[i*W +: W];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tx_done   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    model_last = N - 1;
    model_txd  = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_data  = $urandom;
    tx_done   = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({req_ready, tx_start, tx_data, grant_id, busy, timeout_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {req_ready, tx_start, tx_data, grant_id, busy, timeout_err});
    end
    req_valid = '0;
    reset_n   = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: got start=%0b busy=%0b expected 0 0", tx_start, busy);
    end
    model_last = N - 1;
    model_txd  = '0;
  endtask

  task automatic test_single();
    req_data          = $urandom;
    req_data[2*W +: W] = 8'hA5;
    req_valid         = 4'b0100;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || req_ready !== 4'b0100 ||
        int'(grant_id) !== 2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: got start=%0b data=%0h ready=%0b gid=%0d busy=%0b expected 1 a5 0100 2 1",
               tx_start, tx_data, req_ready, grant_id, busy);
    end
    req_valid = '0;
    tick();
    tests_run++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_hold: got start=%0b ready=%0b busy=%0b expected 0 0000 1",
               tx_start, req_ready, busy);
    end
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_done: got busy=%0b data=%0h expected 0 a5", busy, tx_data);
    end
    model_last = 2;
    model_txd  = 8'hA5;
  endtask

  task automatic test_random_arb();
    for (int it = 0; it < 30; it++) begin
      logic [N-1:0] v;
      int exp;
      int k;
      v         = N'($urandom_range(1, (1 << N) - 1));
      req_data  = $urandom;
      exp       = rr_pick(model_last, v);
      req_valid = v;
      tick();
      tests_run++;
      if (tx_start !== 1'b1 || int'(grant_id) !== exp ||
          tx_data !== byte_of(req_data, exp) || req_ready !== (4'b0001 << exp) || busy !== 1'b1) begin
        fails++;
        $display("FAIL rand_grant[%0d]: got start=%0b gid=%0d data=%0h ready=%0b expected 1 %0d %0h %0b",
                 it, tx_start, grant_id, tx_data, req_ready, exp, byte_of(req_data, exp), 4'b0001 << exp);
      end
      req_valid  = '0;
      model_last = exp;
      model_txd  = byte_of(req_data, exp);
      k = $urandom_range(0, 6);
      if (k == 0) begin
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end else begin
        tick();
        tests_run++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL rand_wait[%0d]: got start=%0b busy=%0b expected 0 1", it, tx_start, busy);
        end
        repeat (k - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end
      tests_run++;
      if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== model_txd) begin
        fails++;
        $display("FAIL rand_done[%0d]: got busy=%0b start=%0b data=%0h expected 0 0 %0h",
                 it, busy, tx_start, tx_data, model_txd);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_back_to_back();
    int starts;
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      int exp;
      exp = rr_pick(model_last, 4'b1111);
      tests_run++;
      if (tx_start !== 1'b1 || int'(grant_id) !== exp ||
          tx_data !== byte_of(req_data, exp) || req_ready !== (4'b0001 << exp)) begin
        fails++;
        $display("FAIL b2b_grant[%0d]: got start=%0b gid=%0d data=%0h expected 1 %0d %0h",
                 g, tx_start, grant_id, tx_data, exp, byte_of(req_data, exp));
      end
      model_last = exp;
      req_data[exp*W +: W] = W'($urandom);
      starts = 0;
      for (int c = 1; c < GAP; c++) begin
        tick();
        if (tx_start === 1'b1) starts++;
      end
      if (g == 4) req_valid = '0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tests_run++;
      if (starts !== 0 || busy !== 1'b0 || tx_start !== 1'b0) begin
        fails++;
        $display("FAIL b2b_done[%0d]: got extra_starts=%0d busy=%0b start=%0b expected 0 0 0",
                 g, starts, busy, tx_start);
      end
      if (g < 4) tick();
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b0010;
    tick();
    tests_run++;
    if (int'(grant_id) !== 1) begin
      fails++;
      $display("FAIL fair_seed: got gid=%0d expected 1", grant_id);
    end
    model_last = 1;
    req_valid  = '0;
    tx_done    = 1'b1;
    tick();
    tx_done   = 1'b0;
    req_valid = 4'b1010;
    tick();
    for (int g = 0; g < 4; g++) begin
      int exp;
      exp = rr_pick(model_last, 4'b1010);
      tests_run++;
      if (tx_start !== 1'b1 || int'(grant_id) !== exp) begin
        fails++;
        $display("FAIL fair_grant[%0d]: got start=%0b gid=%0d expected 1 %0d", g, tx_start, grant_id, exp);
      end
      model_last = exp;
      tick();
      if (g == 3) req_valid = '0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (g < 3) tick();
    end
    model_txd = tx_data;
  endtask

  task automatic test_spurious_done();
    logic [W-1:0] held;
    held    = tx_data;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== held) begin
        fails++;
        $display("FAIL spurious_done[%0d]: got start=%0b busy=%0b data=%0h expected 0 0 %0h",
                 c, tx_start, busy, tx_data, held);
      end
    end
    req_valid = 4'b1111;
    #2;
    req_valid = '0;
    repeat (2) tick();
    tests_run++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL valid_glitch: got start=%0b busy=%0b expected 0 0", tx_start, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (2) tick();
    tests_run++;
    if (busy !== 1'b1 || int'(grant_id) !== 2) begin
      fails++;
      $display("FAIL rst_mid_pre: got busy=%0b gid=%0d expected 1 2", busy, grant_id);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, tx_start, tx_data, grant_id, busy, timeout_err} !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: got %0h expected 0",
               {req_ready, tx_start, tx_data, grant_id, busy, timeout_err});
    end
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || int'(grant_id) !== 0) begin
      fails++;
      $display("FAIL rst_mid_after: got start=%0b gid=%0d expected 1 0", tx_start, grant_id);
    end
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b1111;
    tick();
    tests_run++;
    if (tx_start !== 1'b1 || int'(grant_id) !== 0) begin
      fails++;
      $display("FAIL to_grant: got start=%0b gid=%0d expected 1 0", tx_start, grant_id);
    end
    early = 0;
    for (int c = 1; c < TO; c++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
    end
    tests_run++;
    if (early !== 0) begin
      fails++;
      $display("FAIL to_early: got %0d bad cycles expected 0", early);
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse: got err=%0b busy=%0b expected 1 0", timeout_err, busy);
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b0 || tx_start !== 1'b1 || int'(grant_id) !== rr_pick(0, 4'b1111)) begin
      fails++;
      $display("FAIL to_next: got err=%0b start=%0b gid=%0d expected 0 1 %0d",
               timeout_err, tx_start, grant_id, rr_pick(0, 4'b1111));
    end
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask
`else
  task automatic test_timeout();
    int bad;
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", bad);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout_done: got busy=%0b err=%0b expected 0 0", busy, timeout_err);
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    test_reset();
    test_single();
    test_random_arb();
    test_spurious_done();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
